// File: rtl/pf_rom_arbiter.sv
// Round-robin arbiter for three playfield tile fetches onto one 64-bit SDRAM read port.
// Optional per-port one-line cache enabled by defining PF_ROM_CACHE_EN.
module pf_rom_arbiter #(
   parameter logic [24:0] BASE_ADDR = 25'h000000
) (
   input  logic        CLK_32M,
   input  logic        RESET,
   input  logic [20:0] addr_a,
   input  logic [20:0] addr_b,
   input  logic [20:0] addr_c,
   input  logic        req_a,
   input  logic        req_b,
   input  logic        req_c,
   output logic [31:0] data_a,
   output logic [31:0] data_b,
   output logic [31:0] data_c,
   output logic        rdy_a,
   output logic        rdy_b,
   output logic        rdy_c,
   output logic [24:0] sdr_addr,
   output logic        sdr_req,
   input  logic [63:0] sdr_data,
   input  logic        sdr_rdy,
   input  logic        flush
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t      st;
   logic [1:0]  ptr;
   logic [1:0]  gnt;
   logic        gsel;
   logic [2:0]  mask;
   logic [2:0]  elig;
   logic [1:0]  win;
   logic [1:0]  p;
   logic        found;
   logic [20:0] waddr;
   logic        hit;
   logic [31:0] hit_word;
   logic        fin;
   logic [1:0]  fin_port;
   logic [31:0] fin_word;

   function automatic logic [1:0] nxt(input logic [1:0] q);
      return (q == 2'd2) ? 2'd0 : q + 2'd1;
   endfunction

   // A port is blocked for one cycle after its rdy so a late drop is not re-served
   assign elig = {req_c, req_b, req_a} & ~mask;

   always_comb begin
      found = 1'b0;
      win   = ptr;
      p     = ptr;
      for (int i = 0; i < 3; i++) begin
         if (!found && elig[p]) begin
            found = 1'b1;
            win   = p;
         end
         p = nxt(p);
      end
   end

   always_comb begin
      case (win)
         2'd1:    waddr = addr_b;
         2'd2:    waddr = addr_c;
         default: waddr = addr_a;
      endcase
   end

`ifdef PF_ROM_CACHE_EN
   logic [2:0]  cvalid;
   logic [19:0] ctag  [3];
   logic [63:0] cline [3];
   logic [19:0] gtag;

   always_comb begin
      hit      = found && cvalid[win] && (ctag[win] == waddr[20:1]);
      hit_word = waddr[0] ? cline[win][63:32] : cline[win][31:0];
   end

   always_ff @(posedge CLK_32M or posedge RESET) begin
      if (RESET) begin
         cvalid <= '0;
         gtag   <= '0;
         for (int i = 0; i < 3; i++) begin
            ctag[i]  <= '0;
            cline[i] <= '0;
         end
      end else begin
         if (st == IDLE && found)
            gtag <= waddr[20:1];
         if (st == WAIT && sdr_rdy) begin
            ctag[gnt]   <= gtag;
            cline[gnt]  <= sdr_data;
            cvalid[gnt] <= 1'b1;
         end
         // flush overrides a fill landing in the same cycle
         if (flush)
            cvalid <= '0;
      end
   end
`else
   logic unused_flush;

   assign hit          = 1'b0;
   assign hit_word     = '0;
   assign unused_flush = flush;
`endif

   always_comb begin
      fin      = 1'b0;
      fin_port = gnt;
      fin_word = gsel ? sdr_data[63:32] : sdr_data[31:0];
      if (st == IDLE && found && hit) begin
         fin      = 1'b1;
         fin_port = win;
         fin_word = hit_word;
      end else if (st == WAIT && sdr_rdy) begin
         fin = 1'b1;
      end
   end

   always_ff @(posedge CLK_32M or posedge RESET) begin
      if (RESET) begin
         st       <= IDLE;
         ptr      <= 2'd0;
         gnt      <= 2'd0;
         gsel     <= 1'b0;
         mask     <= '0;
         sdr_req  <= 1'b0;
         sdr_addr <= BASE_ADDR;
         rdy_a    <= 1'b0;
         rdy_b    <= 1'b0;
         rdy_c    <= 1'b0;
         data_a   <= '0;
         data_b   <= '0;
         data_c   <= '0;
      end else begin
         mask    <= {rdy_c, rdy_b, rdy_a};
         sdr_req <= 1'b0;
         unique case (st)
            IDLE: begin
               if (found) begin
                  gnt  <= win;
                  gsel <= waddr[0];
                  ptr  <= nxt(win);
                  if (hit) begin
                     st <= DONE;
                  end else begin
                     st       <= ISSUE;
                     sdr_req  <= 1'b1;
                     sdr_addr <= BASE_ADDR + {2'b00, waddr[20:1], 3'b000};
                  end
               end
            end
            ISSUE: st <= WAIT;
            WAIT:  if (sdr_rdy) st <= DONE;
            DONE:  st <= IDLE;
            default: st <= IDLE;
         endcase
         rdy_a <= fin && (fin_port == 2'd0);
         rdy_b <= fin && (fin_port == 2'd1);
         rdy_c <= fin && (fin_port == 2'd2);
         if (fin && fin_port == 2'd0) data_a <= fin_word;
         if (fin && fin_port == 2'd1) data_b <= fin_word;
         if (fin && fin_port == 2'd2) data_c <= fin_word;
      end
   end

endmodule
